// File: rtl/lector_contadores.sv
// Sweeps counter indices 0..NUM_IDX-1 with a one-cycle req handshake and latches each returned count.
// Optional WAIT timeout enabled by macro LECTOR_TIMEOUT_EN.
module lector_cnt_lane (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       we_i,
  input  logic [5:0] d_i,
  output logic [5:0] q_o
);
  logic [5:0] cnt_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)  cnt_q <= '0;
    else if (we_i) cnt_q <= d_i;
  end

  assign q_o = cnt_q;
endmodule

module lector_contadores #(
  parameter int NUM_IDX = 5,
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       start,
  output logic       req,
  output logic [2:0] idx,
  input  logic [5:0] data_in,
  input  logic       valid_in,
  output logic [5:0] cnt0,
  output logic [5:0] cnt1,
  output logic [5:0] cnt2,
  output logic [5:0] cnt3,
  output logic [5:0] cnt4,
  output logic       busy,
  output logic       done,
  output logic       error
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        cap;
  logic [5:0]                  wr_data;
  logic                        last;
  logic [NUM_IDX-1:0][5:0]     cnt_all;
  logic [4:0][5:0]             cnt_out;

`ifdef LECTOR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  assign last = (idx_q == 3'(NUM_IDX-1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    wr_data = data_in;
`ifdef LECTOR_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_REQ;
`ifdef LECTOR_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
`ifdef LECTOR_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_WAIT: begin
        if (valid_in) cap = 1'b1;
`ifdef LECTOR_TIMEOUT_EN
        // An abandoned index reads back as zero so stale counts are never mistaken for fresh ones.
        else if (tmo_q == TMO_W'(TIMEOUT-1)) begin
          cap     = 1'b1;
          wr_data = '0;
          err_d   = 1'b1;
        end
        else tmo_d = tmo_q + TMO_W'(1);
`endif
        if (cap) begin
          if (last) state_d = S_DONE;
          else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
`ifdef LECTOR_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef LECTOR_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  for (genvar g = 0; g < NUM_IDX; g++) begin : g_lane
    lector_cnt_lane u_lane (
      .clk     (clk),
      .reset_L (reset_L),
      .we_i    (cap && (idx_q == 3'(g))),
      .d_i     (wr_data),
      .q_o     (cnt_all[g])
    );
  end

  for (genvar k = 0; k < 5; k++) begin : g_out
    if (k < NUM_IDX) begin : g_on
      assign cnt_out[k] = cnt_all[k];
    end else begin : g_off
      assign cnt_out[k] = '0;
    end
  end

  assign cnt0 = cnt_out[0];
  assign cnt1 = cnt_out[1];
  assign cnt2 = cnt_out[2];
  assign cnt3 = cnt_out[3];
  assign cnt4 = cnt_out[4];

  assign req  = (state_q == S_REQ);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign idx  = idx_q;
`ifdef LECTOR_TIMEOUT_EN
  assign error = err_q;
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_lector_contadores.sv
// Scoreboard bench for lector_contadores: expected req indices and done cycles are queued at stimulus time.
module tb_lector_contadores;
  logic       clk = 0, reset_L = 1, start = 0, valid_in = 0;
  logic [5:0] data_in = 0;
  logic       req, busy, done, error;
  logic [2:0] idx;
  logic [5:0] cnt0, cnt1, cnt2, cnt3, cnt4;

  int nchk = 0, npass = 0, cyc = 0;
  logic [5:0] mem [8];
  int  dly [8];
  bit  mute [8];
  bit  man = 0;
  int  cnt_wait = 0, pidx = 0, s = 0;
  int  exp_idx [$];
  int  exp_done [$];

  lector_contadores dut (
    .clk(clk), .reset_L(reset_L), .start(start), .req(req), .idx(idx),
    .data_in(data_in), .valid_in(valid_in),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3), .cnt4(cnt4),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    else npass++;
  endtask

  // Counter-block model plus scoreboard pop side.
  always @(negedge clk) begin
    if (!man) begin valid_in = 0; data_in = 0; end
    if (cnt_wait > 0) begin
      cnt_wait--;
      if (cnt_wait == 0 && !man) begin valid_in = 1; data_in = mem[pidx]; end
    end
    if (req) begin
      if (exp_idx.size() == 0) chk("req_unexp", 1, 0);
      else chk("req_idx", 64'(idx), 64'(exp_idx.pop_front()));
      if (!mute[idx]) begin pidx = int'(idx); cnt_wait = 1 + dly[idx]; end
    end
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexp", 1, 0);
      else chk("done_cyc", 64'(cyc), 64'(exp_done.pop_front()));
    end
  end

  task automatic sweep(input int extra);
    @(negedge clk); start = 1;
    for (int i = 0; i < 5; i++) exp_idx.push_back(i);
    @(negedge clk); start = 0;
    s = cyc;
    exp_done.push_back(s + 10 + extra);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_idx.size() + exp_done.size()) != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    chk("sb_drain", 64'(exp_idx.size() + exp_done.size()), 0);
  endtask

  task automatic set_mem(input logic [5:0] a, b, c, d, e);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d; mem[4] = e;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mem[i] = 0; dly[i] = 0; mute[i] = 0; end
    #1 reset_L = 0;
    #1 chk("rst_out", {req, idx, busy, done, error, cnt0, cnt1, cnt2, cnt3, cnt4}, 0);
    repeat (2) @(negedge clk);
    reset_L = 1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Single sweep with fixed one-cycle latency.
    set_mem(3, 0, 15, 7, 1);
    sweep(0);
    drain(40);
    chk("t1_cnt", {cnt0, cnt1, cnt2, cnt3, cnt4}, {6'd3, 6'd0, 6'd15, 6'd7, 6'd1});
    chk("t1_err", error, 0);
    chk("t1_busy", busy, 0);

    // Start held 20 cycles: DONE ignores start, IDLE re-accepts it once.
    set_mem(5, 10, 20, 40, 63);
    @(negedge clk); start = 1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < 5; i++) exp_idx.push_back(i);
    @(negedge clk);
    s = cyc;
    exp_done.push_back(s + 10);
    exp_done.push_back(s + 22);
    repeat (19) @(negedge clk);
    start = 0;
    drain(60);
    chk("t2_cnt", {cnt0, cnt1, cnt2, cnt3, cnt4}, {6'd5, 6'd10, 6'd20, 6'd40, 6'd63});

    // Spurious valid while idle.
    @(negedge clk); #1;
    man = 1; valid_in = 1; data_in = 6'h3F;
    repeat (3) @(negedge clk);
    #1 chk("t4_busy", busy, 0);
    man = 0; valid_in = 0; data_in = 0;
    repeat (2) @(negedge clk);
    chk("t4_cnt", {cnt0, cnt1, cnt2, cnt3, cnt4}, {6'd5, 6'd10, 6'd20, 6'd40, 6'd63});

    // Async reset while waiting on index 2.
    set_mem(11, 12, 13, 14, 15);
    @(negedge clk); start = 1;
    for (int i = 0; i < 3; i++) exp_idx.push_back(i);
    @(negedge clk); start = 0;
    for (int i = 0; i < 20 && exp_idx.size() != 0; i++) begin @(negedge clk); #1; end
    chk("t3_reached", 64'(exp_idx.size()), 0);
    @(posedge clk); #2;
    chk("t3_wait", {req, busy, idx}, {1'b0, 1'b1, 3'd2});
    reset_L = 0;
    #1 chk("t3_rst", {req, idx, busy, done, error, cnt0, cnt1, cnt2, cnt3, cnt4}, 0);
    @(negedge clk); reset_L = 1;
    repeat (10) @(negedge clk);
    chk("t3_idle", {busy, cnt0, cnt1, cnt2, cnt3, cnt4}, 0);

`ifdef LECTOR_TIMEOUT_EN
    // Index 3 never answers: 4 WAIT cycles instead of 1.
    set_mem(21, 22, 23, 24, 25);
    mute[3] = 1;
    sweep(3);
    drain(60);
    chk("t6_cnt", {cnt0, cnt1, cnt2, cnt3, cnt4}, {6'd21, 6'd22, 6'd23, 6'd0, 6'd25});
    chk("t6_err", error, 1);
    mute[3] = 0;
    sweep(0);
    chk("t6_errclr", error, 0);
    drain(40);
    chk("t6_cnt3", cnt3, 24);
    chk("t6_err2", error, 0);
`else
    // Index 1 answers 9 cycles late; WAIT holds without re-requesting.
    set_mem(1, 2, 3, 4, 5);
    dly[1] = 9;
    sweep(9);
    drain(60);
    chk("t5_cnt", {cnt0, cnt1, cnt2, cnt3, cnt4}, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5});
    chk("t5_err", error, 0);
    dly[1] = 0;
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
